// File: rtl/hs_pkg.sv
// Shared types and default constants for the hs_sink async-to-sync handshake sink.
package hs_pkg;

  localparam int HS_DATA_W      = 8;
  localparam int HS_DEPTH       = 4;
  localparam int HS_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } hs_state_t;

endpackage

// File: rtl/hs_sink_if.sv
// Bundle of the request/acknowledge side and the valid/ready FIFO read side of hs_sink.
interface hs_sink_if
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int DEPTH  = HS_DEPTH
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              req_out;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output req_out, data_in, m_ready,
    input  ack_out, m_data, m_valid, count
  );

  modport slave (
    input  req_out, data_in, m_ready,
    output ack_out, m_data, m_valid, count
  );

endinterface

// File: rtl/hs_sync.sv
// N-flop single-bit synchronizer with synchronous reset to 0.
module hs_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/hs_sink.sv
// Tail of the micropipeline: 4-phase RTZ acknowledge plus show-ahead FIFO read out by valid/ready.
// Optional statistics (tok_cnt, stall) are built when HS_SINK_STATS_EN is defined.
module hs_sink
  import hs_pkg::*;
#(
  parameter int DATA_W      = HS_DATA_W,
  parameter int DEPTH       = HS_DEPTH,
  parameter int SYNC_STAGES = HS_SYNC_STAGES
) (
  input  logic        clk,
  input  logic        rst,
  hs_sink_if.slave    bus
`ifdef HS_SINK_STATS_EN
  ,
  output logic [15:0] tok_cnt,
  output logic        stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic              req_s;
  hs_state_t         state_q, state_d;
  logic              ack_q, ack_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push;
  logic              pop;
  logic              full;

  hs_sync #(.N(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.req_out),
    .q   (req_s)
  );

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) && bus.m_ready;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_s && !full) begin
          push    = 1'b1;
          ack_d   = 1'b0;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!req_s) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ack_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the read mux below hides stale
  // contents whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.ack_out = ack_q;
  assign bus.m_valid = (count_q != '0);
  assign bus.m_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.count   = count_q;

`ifdef HS_SINK_STATS_EN
  logic [15:0] tok_cnt_q, tok_cnt_d;

  always_comb begin
    tok_cnt_d = tok_cnt_q + 16'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) tok_cnt_q <= '0;
    else     tok_cnt_q <= tok_cnt_d;
  end

  assign tok_cnt = tok_cnt_q;
  assign stall   = (state_q == IDLE) && req_s && full;
`endif

endmodule

// File: tb/tb_hs_sink.sv
// Directed/randomized bench for hs_sink with a queue-based reference model and handshake monitor.
module tb_hs_sink;
  import hs_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hs_sink_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef HS_SINK_STATS_EN
  logic [15:0] tok_cnt;
  logic        stall;
`endif

  hs_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef HS_SINK_STATS_EN
    ,
    .tok_cnt (tok_cnt),
    .stall   (stall)
`endif
  );

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] model_q [$];
  int writes_m  = 0;
  int max_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference synchronizer: req_out delayed by SYNC rising edges, cleared by reset.
  logic [SYNC-1:0] sync_m;
  always @(posedge clk) begin
    if (rst) sync_m <= '0;
    else     sync_m <= {sync_m[SYNC-2:0], bus.req_out};
  end

  // Monitor: handshake protocol, scoreboard on pops, peak occupancy.
  logic ack_prev, req_s_prev, rst_prev;
  bit   mon_valid = 1'b0;
  always @(negedge clk) begin
    if (mon_valid && !rst_prev) begin
      if (ack_prev && !bus.ack_out)  check("proto_fall_needs_req_s", 32'(req_s_prev), 32'd1);
      if (!ack_prev && bus.ack_out)  check("proto_rise_needs_no_req_s", 32'(req_s_prev), 32'd0);
    end
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (model_q.size() == 0) check("pop_unexpected_valid", 32'(bus.m_valid), 32'd0);
      else                     check("pop_data", 32'(bus.m_data), 32'(model_q.pop_front()));
    end
    if (int'(bus.count) > max_count) max_count = int'(bus.count);
    ack_prev   = bus.ack_out;
    req_s_prev = sync_m[SYNC-1];
    rst_prev   = rst;
    mon_valid  = 1'b1;
  end

  task automatic wait_ack(input logic val, input int budget, input string tag);
    int n = 0;
    while (bus.ack_out !== val && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.ack_out), 32'(val));
  endtask

  task automatic send_token(input logic [DATA_W-1:0] d);
    bus.data_in = d;
    bus.req_out = 1'b1;
    model_q.push_back(d);
    wait_ack(1'b0, 40, "send_ack_fall");
    writes_m++;
    bus.req_out = 1'b0;
    wait_ack(1'b1, 40, "send_ack_rise");
  endtask

  task automatic drain();
    int n = 0;
    bus.m_ready = 1'b1;
    while (bus.m_valid && n < 4 * DEPTH) begin
      tick();
      n++;
    end
    bus.m_ready = 1'b0;
    check("drain_empty", 32'(bus.m_valid), 32'd0);
    check("drain_model_empty", 32'(model_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d, t2;

    rst         = 1'b1;
    bus.req_out = 1'b0;
    bus.data_in = '0;
    bus.m_ready = 1'b0;
    repeat (3) tick();
    check("rst_ack", 32'(bus.ack_out), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
`ifdef HS_SINK_STATS_EN
    check("rst_tok_cnt", 32'(tok_cnt), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Single token: exact acknowledge latency in both directions.
    bus.data_in = 8'hA5;
    bus.req_out = 1'b1;
    model_q.push_back(8'hA5);
    for (int e = 1; e <= LAT; e++) begin
      tick();
      check("t1_ack_after_rise", 32'(bus.ack_out), (e == LAT) ? 32'd0 : 32'd1);
    end
    writes_m++;
    check("t1_m_valid", 32'(bus.m_valid), 32'd1);
    check("t1_m_data", 32'(bus.m_data), 32'hA5);
    check("t1_count", 32'(bus.count), 32'd1);
    bus.req_out = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      check("t1_ack_after_fall", 32'(bus.ack_out), (e == LAT) ? 32'd1 : 32'd0);
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check("t1_count_after_pop", 32'(bus.count), 32'd0);
    check("t1_m_data_empty", 32'(bus.m_data), 32'd0);

    // Fill to DEPTH, fifth token must be held off until a pop frees a slot.
    for (int i = 1; i <= DEPTH; i++) send_token(DATA_W'(i));
    check("t2_count_full", 32'(bus.count), 32'(DEPTH));
    bus.data_in = 8'h05;
    bus.req_out = 1'b1;
    model_q.push_back(8'h05);
    repeat (12) tick();
    check("t2_ack_held", 32'(bus.ack_out), 32'd1);
    check("t2_count_held", 32'(bus.count), 32'(DEPTH));
`ifdef HS_SINK_STATS_EN
    check("t2_stall", 32'(stall), 32'd1);
`endif
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check("t2_count_after_pop", 32'(bus.count), 32'(DEPTH - 1));
    wait_ack(1'b0, 2, "t2_ack_after_pop");
    writes_m++;
    check("t2_count_refilled", 32'(bus.count), 32'(DEPTH));
    bus.req_out = 1'b0;
    wait_ack(1'b1, 10, "t2_ack_rise");
    drain();
`ifdef HS_SINK_STATS_EN
    check("t2_tok_cnt", 32'(tok_cnt), 32'(writes_m));
`endif

    // Simultaneous push and pop at count = 2.
    send_token(DATA_W'($urandom));
    t2 = DATA_W'($urandom);
    send_token(t2);
    check("t3_count_before", 32'(bus.count), 32'd2);
    d = DATA_W'($urandom);
    bus.data_in = d;
    bus.req_out = 1'b1;
    model_q.push_back(d);
    repeat (LAT - 1) tick();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    writes_m++;
    check("t3_ack_low", 32'(bus.ack_out), 32'd0);
    check("t3_count_same", 32'(bus.count), 32'd2);
    check("t3_m_data_next", 32'(bus.m_data), 32'(t2));
    bus.req_out = 1'b0;
    wait_ack(1'b1, 10, "t3_ack_rise");
    drain();

    // Streaming with the consumer always ready: pointers wrap, occupancy stays at most 1.
    bus.m_ready = 1'b1;
    max_count   = 0;
    for (int i = 0; i < 10; i++) send_token(DATA_W'($urandom));
    repeat (2) tick();
    check("t4_max_count", 32'(max_count), 32'd1);
    drain();
`ifdef HS_SINK_STATS_EN
    check("t4_tok_cnt", 32'(tok_cnt), 32'(writes_m));
`endif

    // Reset while waiting for req to drop, with two tokens stored.
    send_token(DATA_W'($urandom));
    d = DATA_W'($urandom);
    bus.data_in = d;
    bus.req_out = 1'b1;
    model_q.push_back(d);
    wait_ack(1'b0, 10, "t5_ack_fall");
    writes_m++;
    check("t5_count_two", 32'(bus.count), 32'd2);
    rst = 1'b1;
    tick();
    check("t5_rst_ack", 32'(bus.ack_out), 32'd1);
    check("t5_rst_count", 32'(bus.count), 32'd0);
    check("t5_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("t5_rst_m_data", 32'(bus.m_data), 32'd0);
    model_q.delete();
    writes_m = 0;
    // req_out still high after reset: seen as a fresh token.
    model_q.push_back(d);
    rst = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      check("t5_ack_new_token", 32'(bus.ack_out), (e == LAT) ? 32'd0 : 32'd1);
    end
    writes_m++;
    check("t5_m_data", 32'(bus.m_data), 32'(d));
    check("t5_count_one", 32'(bus.count), 32'd1);
    bus.req_out = 1'b0;
    wait_ack(1'b1, 10, "t5_ack_rise");
    drain();
`ifdef HS_SINK_STATS_EN
    check("t5_tok_cnt", 32'(tok_cnt), 32'(writes_m));
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
